pipelined_adder_sub: RTL

- Parametrised successor to the team's flat 16-bit ripple-carry adder benchmark: WIDTH-bit add/subtract with carry-in, carry-out and signed overflow.
- Carry chain split into STAGES equal slices, one register stage per slice, with valid/ready handshake on both sides.
- Serves as a sequential training/benchmark block for the power-aware synthesis flow, where pipeline depth and width are swept as parameters.

---
 rtl/pipelined_adder_sub_if.sv | 30 +++
 rtl/pipelined_adder_sub.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipelined_adder_sub_if.sv
// pipelined_adder_sub_if -- handshake bus for the pipelined adder/subtractor.
//   Input side : in_valid/in_ready, operands in_a/in_b, in_cin, in_sub (1 = A - B - borrow).
//   Output side: out_valid/out_ready, out_sum, out_cout (raw MSB carry), out_ovf (signed overflow).
//   slave  : the adder side of the bus.
//   master : the producer/consumer side of the bus.
interface pipelined_adder_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub -- WIDTH-bit add/subtract with the carry chain cut into
// STAGES equal slices, one register stage per slice.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pipelined_adder_sub_if.slave (valid/ready in, valid/ready out)
// Subtract is A + ~B + ~cin, so out_cout = 1 means "no borrow".
// The whole pipe advances on one global enable; a stalled output freezes
// every stage, valid bits included.

// One slice of the carry chain: plain W-bit adder with carry in/out.
module pas_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
  assign o_s    = w_full[W-1:0];
  assign o_co   = w_full[W];
endmodule

module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_adder_sub_if.slave  bus
);
  localparam int WS = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic [STAGES:1]  vld_pipe;   // vld_pipe[k] = valid of register stage k-1
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_cout;
  logic             r_out_ovf;

  // Global enable: the pipe moves whenever the output slot is free or drained.
  assign w_adv         = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_ovf   = r_out_ovf;

  assign w_b_eff = bus.in_sub ? ~bus.in_b   : bus.in_b;
  assign w_c_eff = bus.in_sub ? ~bus.in_cin : bus.in_cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (w_adv) begin
      vld_pipe[1] <= bus.in_valid;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits not yet consumed when this stage runs (skew window).
    localparam int RW = WIDTH - k*WS;

    logic [RW-1:0]         w_ra;
    logic [RW-1:0]         w_rb;
    logic                  w_ci;
    logic [WS-1:0]         w_s;
    logic                  w_co;
    logic [(k+1)*WS-1:0]   w_sacc;  // result slices 0..k (deskew window)

    pas_slice #(.W(WS)) u_slice (
      .i_a  (w_ra[WS-1:0]),
      .i_b  (w_rb[WS-1:0]),
      .i_ci (w_ci),
      .o_s  (w_s),
      .o_co (w_co)
    );

    if (k == 0) begin : g_src
      assign w_ra   = bus.in_a;
      assign w_rb   = w_b_eff;
      assign w_ci   = w_c_eff;
      assign w_sacc = w_s;
    end else begin : g_src
      assign w_ra   = g_stg[k-1].g_fwd.r_a;
      assign w_rb   = g_stg[k-1].g_fwd.r_b;
      assign w_ci   = g_stg[k-1].g_fwd.r_c;
      assign w_sacc = {w_s, g_stg[k-1].g_fwd.r_s};
    end

    if (k < STAGES-1) begin : g_fwd
      // Datapath only; validity lives in vld_pipe, so no reset needed.
      logic [RW-WS-1:0]    r_a;
      logic [RW-WS-1:0]    r_b;
      logic                r_c;
      logic [(k+1)*WS-1:0] r_s;

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a <= w_ra[RW-1:WS];
          r_b <= w_rb[RW-1:WS];
          r_c <= w_co;
          r_s <= w_sacc;
        end
      end
    end else begin : g_last
      // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
      logic w_cm;
      assign w_cm = w_ra[WS-1] ^ w_rb[WS-1] ^ w_s[WS-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_out_sum  <= '0;
          r_out_cout <= 1'b0;
          r_out_ovf  <= 1'b0;
        end else if (w_adv) begin
          r_out_sum  <= w_sacc;
          r_out_cout <= w_co;
          r_out_ovf  <= w_cm ^ w_co;
        end
      end
    end
  end
endmodule
